// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter and transaction sequencer sharing one spi_master among requesters
module spi_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 50_000,
    parameter int GUARD_CYCLES   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic [NUM_REQ-1:0]            dev_sel_o,
    output logic                          m_start_o,
    output logic [DATA_WIDTH-1:0]         m_tx_data_o,
    input  logic                          m_busy_i,
    input  logic                          m_done_i,
    input  logic [DATA_WIDTH-1:0]         m_rx_data_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, GUARD} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           grant_q, grant_d, last_q, last_d, win;
    logic                    found;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [GW-1:0]           gcnt_q, gcnt_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, dev_sel_q, dev_sel_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d, m_tx_data_q, m_tx_data_d;
    logic                    rsp_err_q, rsp_err_d, m_start_q, m_start_d;

    // Round-robin search: scan downward so the requester closest after last_q is written last and wins
    always_comb begin
        found = 1'b0;
        win   = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid_i[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and next-output logic; every output is produced one cycle ahead so it leaves a register
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        gcnt_d      = gcnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        dev_sel_d   = dev_sel_q;
        m_start_d   = 1'b0;
        m_tx_data_d = m_tx_data_q;
        case (state_q)
            IDLE: if (found && !m_busy_i) begin
                grant_d     = win;
                last_d      = win;
                m_tx_data_d = req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
                m_start_d   = 1'b1;
                req_ready_d = NUM_REQ'(1) << win;
                dev_sel_d   = NUM_REQ'(1) << win;
                state_d     = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (m_done_i || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                rsp_valid_d = NUM_REQ'(1) << grant_q;
                rsp_data_d  = m_done_i ? m_rx_data_i : '0;
                rsp_err_d   = !m_done_i;
                dev_sel_d   = '0;
                gcnt_d      = '0;
                state_d     = GUARD;
            end else begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            end
            GUARD: begin
                gcnt_d  = gcnt_q + 1'b1;
                state_d = (gcnt_q == GW'(GUARD_CYCLES - 1)) ? IDLE : GUARD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset leaves requester 0 with first priority
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IW'(NUM_REQ - 1);
            cnt_q       <= '0;
            gcnt_q      <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            dev_sel_q   <= '0;
            m_start_q   <= 1'b0;
            m_tx_data_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gcnt_q      <= gcnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            dev_sel_q   <= dev_sel_d;
            m_start_q   <= m_start_d;
            m_tx_data_q <= m_tx_data_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign dev_sel_o   = dev_sel_q;
    assign m_start_o   = m_start_q;
    assign m_tx_data_o = m_tx_data_q;
endmodule
